// File: rtl/nvram_arbiter_if.sv
// CPU and HPS ioctl signal bundle for the NVRAM arbiter.
// The slave modport is the arbiter side; the master modport is the core/hps_io side.
interface nvram_arbiter_if;
  logic        cpu_cs;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_hold;

  logic        ioctl_download;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_wr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_hold,
    input  ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
    input  ioctl_wr, ioctl_rd, ioctl_dout,
    output ioctl_din, ioctl_wait
  );

  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_hold,
    output ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
    output ioctl_wr, ioctl_rd, ioctl_dout,
    input  ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/nvram_arbiter.sv
// Shares the single-port 256x8 NVRAM between the game CPU and the HPS ioctl
// channel: fills on reset, stalls the CPU during save/restore, tracks unsaved writes.
module nvram_arbiter #(
  parameter logic [7:0] INDEX    = 8'd4,
  parameter logic [7:0] INIT_VAL = 8'hFF
) (
  input  logic                clk,
  input  logic                reset_n,
  nvram_arbiter_if.slave      bus,
  output logic [7:0]          ram_addr,
  output logic                ram_we,
  output logic [7:0]          ram_wdata,
  input  logic [7:0]          ram_rdata,
  output logic                dirty
);

  typedef enum logic [2:0] {
    S_INIT,
    S_CPU,
    S_DL,
    S_UL_IDLE,
    S_UL_READ
  } state_t;

  state_t      state_q;
  logic [7:0]  fill_q;
  logic        hold_q;
  logic        wait_q;
  logic [7:0]  din_q;
  logic        oor_q;
  logic        dirty_q;

  logic        dl_req;
  logic        ul_req;
  logic        addr_oor;
  logic        cpu_wr;

  assign dl_req   = bus.ioctl_download && (bus.ioctl_index == INDEX);
  assign ul_req   = bus.ioctl_upload   && (bus.ioctl_index == INDEX);
  assign addr_oor = (bus.ioctl_addr[24:8] != '0);
  assign cpu_wr   = bus.cpu_cs && bus.cpu_we;

  assign bus.cpu_dout   = ram_rdata;
  assign bus.cpu_hold   = hold_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.ioctl_din  = din_q;
  assign dirty          = dirty_q;

  // RAM port steering; the CPU path must be same-cycle, so this stays combinational.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    unique case (state_q)
      S_INIT: begin
        ram_addr  = fill_q;
        // Fill strobe is held off while reset is asserted.
        ram_we    = reset_n;
        ram_wdata = INIT_VAL;
      end
      S_CPU: begin
        ram_addr  = bus.cpu_addr;
        ram_we    = cpu_wr;
        ram_wdata = bus.cpu_din;
      end
      S_DL: begin
        ram_addr  = bus.ioctl_addr[7:0];
        ram_we    = bus.ioctl_wr && !addr_oor;
        ram_wdata = bus.ioctl_dout;
      end
      S_UL_IDLE, S_UL_READ: begin
        ram_addr  = bus.ioctl_addr[7:0];
      end
      default: begin
        ram_addr  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      fill_q  <= '0;
      hold_q  <= 1'b1;
      wait_q  <= 1'b0;
      din_q   <= '0;
      oor_q   <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          fill_q <= fill_q + 8'd1;
          if (fill_q == 8'hFF) begin
            state_q <= S_CPU;
            hold_q  <= 1'b0;
          end
        end
        S_CPU: begin
          if (cpu_wr) begin
            dirty_q <= 1'b1;
          end
          // The CPU access in the request cycle still completes above.
          if (dl_req) begin
            state_q <= S_DL;
            hold_q  <= 1'b1;
          end else if (ul_req) begin
            state_q <= S_UL_IDLE;
            hold_q  <= 1'b1;
          end
        end
        S_DL: begin
          if (!dl_req) begin
            state_q <= S_CPU;
            hold_q  <= 1'b0;
            dirty_q <= 1'b0;
          end
        end
        S_UL_IDLE: begin
          if (bus.ioctl_rd) begin
            state_q <= S_UL_READ;
            wait_q  <= 1'b1;
            oor_q   <= addr_oor;
          end else if (!ul_req) begin
            state_q <= S_CPU;
            hold_q  <= 1'b0;
            dirty_q <= 1'b0;
          end
        end
        S_UL_READ: begin
          din_q   <= oor_q ? INIT_VAL : ram_rdata;
          wait_q  <= 1'b0;
          state_q <= S_UL_IDLE;
        end
        default: begin
          state_q <= S_INIT;
          fill_q  <= '0;
          hold_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
